// File: rtl/obc_dft_sequencer.sv
// Bit-serial OBC DFT output-stage sequencer: streams one bit-slice per cycle to
// the external ROM bank and shift-accumulates its summed output into y_out.
module obc_dft_sequencer #(
   parameter int N      = 16,
   parameter int DATA_W = 16,
   parameter int ACC_W  = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [N*DATA_W-1:0]     x_in,
   output logic [N-1:0]            bit_slice,
   input  logic signed [ACC_W-1:0] rom_sum,
   input  logic signed [ACC_W-1:0] rom_offset,
   output logic                    busy,
   output logic signed [ACC_W-1:0] y_out,
   output logic                    y_valid,
   output logic                    done
);

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ACCUM = 2'd1;
   localparam logic [1:0] FINAL = 2'd2;

   logic [1:0]              state;
   logic [CNT_W-1:0]        cnt;
   logic signed [ACC_W-1:0] acc;
   logic [N*DATA_W-1:0]     sreg;
   logic [N*DATA_W-1:0]     sreg_shr;
   logic signed [ACC_W:0]   sum_ext;

   // One guard bit keeps the carry of acc + rom_sum before the halving shift.
   assign sum_ext = {acc[ACC_W-1], acc} + {rom_sum[ACC_W-1], rom_sum};

   assign busy = (state != IDLE);

   always_comb begin
      sreg_shr  = '0;
      bit_slice = '0;
      for (int j = 0; j < N; j++) begin
         sreg_shr[j*DATA_W +: DATA_W] = {1'b0, sreg[j*DATA_W+1 +: DATA_W-1]};
         bit_slice[j]                 = sreg[j*DATA_W];
      end
   end

   // The MSB slice carries negative weight, so it is subtracted without a shift.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         acc     <= '0;
         sreg    <= '0;
         y_out   <= '0;
         y_valid <= 1'b0;
         done    <= 1'b0;
      end else begin
         y_valid <= 1'b0;
         done    <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  sreg  <= x_in;
                  acc   <= '0;
                  cnt   <= '0;
                  state <= ACCUM;
               end
            end
            ACCUM: begin
               sreg <= sreg_shr;
               if (cnt == LAST) begin
                  acc   <= acc - rom_sum;
                  state <= FINAL;
               end else begin
                  acc <= ACC_W'(sum_ext >>> 1);
                  cnt <= cnt + CNT_W'(1);
               end
            end
            FINAL: begin
               y_out   <= acc + rom_offset;
               y_valid <= 1'b1;
               done    <= 1'b1;
               cnt     <= '0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
